// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared write-back request, buffer entry and register-port types
package wb_arbiter_pkg;

  localparam int RD_W   = 5;
  localparam int DATA_W = 32;

  typedef enum logic {
    EXE_ALU = 1'b0,
    EXE_LSU = 1'b1
  } exe_pipe_e;

  typedef struct packed {
    logic              valid;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef struct packed {
    logic              wr_en;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] wr_data;
  } wb_dispatcher_inf_t;

  function automatic wb_entry_t to_entry(input wb_req_t r);
    wb_entry_t e;
    e.rd   = r.rd;
    e.data = r.data;
    return e;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-requester write-back buffer, power-of-two depth, registered pointers
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      empty,
  output logic      full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  // Guarded here too so a misbehaving caller cannot corrupt the count.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges ALU and LSU write-backs onto one register-file port, LSU-first with ALU anti-starvation
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_wb_valid,
  input  logic [RD_W-1:0]   alu_wb_rd,
  input  logic [DATA_W-1:0] alu_wb_data,
  output logic              alu_wb_ready,
  input  logic              lsu_wb_valid,
  input  logic [RD_W-1:0]   lsu_wb_rd,
  input  logic [DATA_W-1:0] lsu_wb_data,
  output logic              lsu_wb_ready,
  output logic              wr_en,
  output logic [RD_W-1:0]   rd,
  output logic [DATA_W-1:0] wr_data,
  output logic              wb_pending
);

  localparam int WW = $clog2(MAX_WAIT + 1) + 1;

  wb_req_t            alu_req, lsu_req;
  wb_entry_t          alu_head, lsu_head, sel_head;
  logic               alu_empty, lsu_empty, alu_full, lsu_full;
  logic               alu_push, lsu_push, sel_alu, sel_lsu, sel_any;
  exe_pipe_e          sel_pipe;
  logic [WW-1:0]      alu_wait;
  wb_dispatcher_inf_t wb_q;

  assign alu_req = '{valid: alu_wb_valid, rd: alu_wb_rd, data: alu_wb_data};
  assign lsu_req = '{valid: lsu_wb_valid, rd: lsu_wb_rd, data: lsu_wb_data};

  assign alu_wb_ready = !alu_full && !rst;
  assign lsu_wb_ready = !lsu_full && !rst;

  // Writes to x0 are accepted and dropped so they never reach the register file.
  assign alu_push = alu_req.valid && alu_wb_ready && (alu_req.rd != '0);
  assign lsu_push = lsu_req.valid && lsu_wb_ready && (lsu_req.rd != '0);

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (alu_push),
    .push_data (to_entry(alu_req)),
    .pop       (sel_alu),
    .head      (alu_head),
    .empty     (alu_empty),
    .full      (alu_full)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_lsu_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (lsu_push),
    .push_data (to_entry(lsu_req)),
    .pop       (sel_lsu),
    .head      (lsu_head),
    .empty     (lsu_empty),
    .full      (lsu_full)
  );

  assign sel_alu  = !alu_empty && (lsu_empty || (alu_wait == WW'(MAX_WAIT)));
  assign sel_lsu  = !lsu_empty && !sel_alu;
  assign sel_any  = sel_alu || sel_lsu;
  assign sel_pipe = sel_alu ? EXE_ALU : EXE_LSU;
  assign sel_head = (sel_pipe == EXE_ALU) ? alu_head : lsu_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_wait <= '0;
      wb_q     <= '0;
    end else begin
      if (alu_empty || sel_alu)            alu_wait <= '0;
      else if (alu_wait != WW'(MAX_WAIT))  alu_wait <= alu_wait + 1'b1;
      wb_q.wr_en <= sel_any;
      if (sel_any) begin
        wb_q.rd      <= sel_head.rd;
        wb_q.wr_data <= sel_head.data;
      end
    end
  end

  assign wr_en      = wb_q.wr_en;
  assign rd         = wb_q.rd;
  assign wr_data    = wb_q.wr_data;
  assign wb_pending = !alu_empty || !lsu_empty;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_wb_valid, lsu_wb_valid;
  logic [4:0]  alu_wb_rd, lsu_wb_rd;
  logic [31:0] alu_wb_data, lsu_wb_data;
  logic        alu_wb_ready, lsu_wb_ready;
  logic        wr_en;
  logic [4:0]  rd;
  logic [31:0] wr_data;
  logic        wb_pending;

  int n_tests = 0;
  int n_fail  = 0;

  wb_arbiter #(.FIFO_DEPTH(2), .MAX_WAIT(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_rd    (alu_wb_rd),
    .alu_wb_data  (alu_wb_data),
    .alu_wb_ready (alu_wb_ready),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_rd    (lsu_wb_rd),
    .lsu_wb_data  (lsu_wb_data),
    .lsu_wb_ready (lsu_wb_ready),
    .wr_en        (wr_en),
    .rd           (rd),
    .wr_data      (wr_data),
    .wb_pending   (wb_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_wb_valid = 1'b0; alu_wb_rd = '0; alu_wb_data = '0;
    lsu_wb_valid = 1'b0; lsu_wb_rd = '0; lsu_wb_data = '0;
  endtask

  task automatic check_write(input string tag, input logic [4:0] exp_rd, input logic [31:0] exp_data);
    check({tag, "_wr_en"}, 64'(wr_en), 64'd1);
    check({tag, "_rd"}, 64'(rd), 64'(exp_rd));
    check({tag, "_data"}, 64'(wr_data), 64'(exp_data));
  endtask

  logic [36:0] aq[$], lq[$], wlog[$];
  logic [4:0]  lsu_exp_rd [6];
  logic [4:0]  star_rd [6];
  logic [31:0] star_data [6];
  bit          alu_blocked;
  int          ai, li;

  initial begin
    idle_inputs();
    rst = 1'b1;

    // reset state
    step(); step();
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_rd", 64'(rd), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_alu_ready", 64'(alu_wb_ready), 64'd0);
    check("rst_lsu_ready", 64'(lsu_wb_ready), 64'd0);
    check("rst_pending", 64'(wb_pending), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_alu_ready", 64'(alu_wb_ready), 64'd1);
    check("post_rst_lsu_ready", 64'(lsu_wb_ready), 64'd1);

    // ALU only: accepted c0, written c2, idle c3
    step();
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'h11;
    #1 check("alu_only_ready", 64'(alu_wb_ready), 64'd1);
    step(); idle_inputs();
    check("alu_only_c1_wr_en", 64'(wr_en), 64'd0);
    check("alu_only_c1_pending", 64'(wb_pending), 64'd1);
    step();
    check_write("alu_only_c2", 5'd5, 32'h11);
    step();
    check("alu_only_c3_wr_en", 64'(wr_en), 64'd0);
    check("alu_only_c3_pending", 64'(wb_pending), 64'd0);

    // contention: LSU first, ALU next
    step();
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd1; alu_wb_data = 32'hA1;
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd2; lsu_wb_data = 32'hB2;
    step(); idle_inputs();
    step(); check_write("cont_c2", 5'd2, 32'hB2);
    step(); check_write("cont_c3", 5'd1, 32'hA1);
    step(); check("cont_c4_wr_en", 64'(wr_en), 64'd0);

    // starvation: LSU streams c0..c4, ALU rd=7 at c0 wins at c5
    star_rd   = '{5'd10, 5'd11, 5'd12, 5'd7, 5'd13, 5'd14};
    star_data = '{32'h100, 32'h101, 32'h102, 32'h77, 32'h103, 32'h104};
    step();
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd7; alu_wb_data = 32'h77;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        step();
        alu_wb_valid = 1'b0;
        if (c >= 2) check_write($sformatf("starve_c%0d", c), star_rd[c-2], star_data[c-2]);
      end
      lsu_wb_valid = 1'b1; lsu_wb_rd = 5'(10 + c); lsu_wb_data = 32'(32'h100 + c);
      #1 check($sformatf("starve_lsu_ready_c%0d", c), 64'(lsu_wb_ready), 64'd1);
    end
    for (int c = 5; c < 8; c++) begin
      step(); idle_inputs();
      check_write($sformatf("starve_c%0d", c), star_rd[c-2], star_data[c-2]);
    end
    step();
    check("starve_c8_wr_en", 64'(wr_en), 64'd0);

    // backpressure: LSU flood of 6, ALU 3 back-to-back
    for (int i = 0; i < 3; i++) aq.push_back({5'(20 + i), 32'(32'hA000 + i)});
    for (int i = 0; i < 6; i++) lq.push_back({5'(1 + i), 32'(32'hB000 + i)});
    lsu_exp_rd = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
    alu_blocked = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (wr_en) wlog.push_back({rd, wr_data});
      alu_wb_valid = (aq.size() > 0);
      lsu_wb_valid = (lq.size() > 0);
      if (alu_wb_valid) {alu_wb_rd, alu_wb_data} = aq[0];
      if (lsu_wb_valid) {lsu_wb_rd, lsu_wb_data} = lq[0];
      #1;
      if (alu_wb_valid && alu_wb_ready) void'(aq.pop_front());
      else if (alu_wb_valid) alu_blocked = 1'b1;
      if (lsu_wb_valid && lsu_wb_ready) void'(lq.pop_front());
    end
    idle_inputs();
    check("bp_alu_ready_low_seen", 64'(alu_blocked), 64'd1);
    check("bp_alu_drained", 64'(aq.size()), 64'd0);
    check("bp_lsu_drained", 64'(lq.size()), 64'd0);
    check("bp_write_count", 64'(wlog.size()), 64'd9);
    ai = 0; li = 0;
    foreach (wlog[k]) begin
      if (wlog[k][36:32] >= 5'd20) begin
        check($sformatf("bp_alu_order_%0d", ai), 64'(wlog[k]), 64'({5'(20 + ai), 32'(32'hA000 + ai)}));
        ai++;
      end else if (li < 6) begin
        check($sformatf("bp_lsu_order_%0d", li), 64'(wlog[k]), 64'({lsu_exp_rd[li], 32'(32'hB000 + li)}));
        li++;
      end else begin
        check("bp_extra_write", 64'(wlog[k]), 64'd0);
      end
    end

    // x0 write is consumed and dropped
    step();
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'hFF;
    #1 check("x0_ready", 64'(alu_wb_ready), 64'd1);
    for (int c = 1; c < 5; c++) begin
      step(); idle_inputs();
      check($sformatf("x0_c%0d_wr_en", c), 64'(wr_en), 64'd0);
      check($sformatf("x0_c%0d_pending", c), 64'(wb_pending), 64'd0);
    end

    // reset with two buffered entries
    step();
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'h33;
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd4; lsu_wb_data = 32'h44;
    step(); idle_inputs();
    check("rst_mid_pending_before", 64'(wb_pending), 64'd1);
    rst = 1'b1;
    #1 check("rst_mid_alu_ready_low", 64'(alu_wb_ready), 64'd0);
    step();
    rst = 1'b0;
    #1;
    check("rst_mid_pending_after", 64'(wb_pending), 64'd0);
    check("rst_mid_alu_ready", 64'(alu_wb_ready), 64'd1);
    check("rst_mid_lsu_ready", 64'(lsu_wb_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("rst_mid_c%0d_wr_en", c), 64'(wr_en), 64'd0);
      check($sformatf("rst_mid_c%0d_pending", c), 64'(wb_pending), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
